// File: rtl/addsub_pkg.sv
`default_nettype none
// ============================================================================
// addsub_pkg : shared FSM state encoding and mode constants for seq_addsub
// Revision   : 1.0
// ============================================================================
package addsub_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

endpackage
`default_nettype wire

// File: rtl/chunk_adder.sv
`default_nettype none
// ============================================================================
// chunk_adder : CHUNK-bit ripple-carry slice with carry-in
// Revision    : 1.0
// ============================================================================
module chunk_adder
  import addsub_pkg::*;
#(
  parameter int CHUNK = 2
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign sum[i]  = a[i] ^ b[i] ^ c[i];
    assign c[i+1]  = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[CHUNK];
  // Carry into the slice MSB; only meaningful for overflow on the top slice.
  assign cmsb = c[CHUNK-1];

endmodule
`default_nettype wire

// File: rtl/seq_addsub.sv
`default_nettype none
// ============================================================================
// seq_addsub : multi-cycle W-bit adder/subtractor, CHUNK bits per clock
// Revision   : 1.0
// ============================================================================
module seq_addsub
  import addsub_pkg::*;
#(
  parameter int W     = 8,
  parameter int CHUNK = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         m,
  output logic         busy,
  output logic         done,
  output logic [W-1:0] s,
  output logic         cout,
  output logic         ovf,
  output logic         zero
);

  localparam int N    = W / CHUNK;
  localparam int IDXW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(N - 1);

  state_t          state_q, state_d;
  logic [W-1:0]    a_q, a_d;
  logic [W-1:0]    b_q, b_d;
  logic [W-1:0]    s_q, s_d;
  logic            carry_q, carry_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic            cout_q, cout_d;
  logic            ovf_q, ovf_d;
  logic            zero_q, zero_d;

  logic [CHUNK-1:0] sum_sl;
  logic             cout_sl;
  logic             cmsb_sl;

  // Operands shift down one slice per cycle so the adder always sees bits [CHUNK-1:0].
  chunk_adder #(
    .CHUNK (CHUNK)
  ) u_chunk_adder (
    .a    (a_q[CHUNK-1:0]),
    .b    (b_q[CHUNK-1:0]),
    .cin  (carry_q),
    .sum  (sum_sl),
    .cout (cout_sl),
    .cmsb (cmsb_sl)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    s_d     = s_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = (m == MODE_ADD) ? b : ~b;
          carry_d = (m == MODE_SUB);
          idx_d   = '0;
          state_d = ST_RUN;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        // Result fills from the top; after N slices slice 0 has reached bit 0.
        s_d     = (s_q >> CHUNK) | (W'(sum_sl) << (W - CHUNK));
        carry_d = cout_sl;
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          cout_d  = cout_sl;
          ovf_d   = cout_sl ^ cmsb_sl;
          zero_d  = (s_d == '0);
          state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
    end
  end

  assign busy = (state_q == ST_RUN);
  assign done = (state_q == ST_DONE);
  assign s    = s_q;
  assign cout = cout_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;

endmodule
`default_nettype wire
